mux4way_merge: RTL

- 4-to-1 stream merger; the gathering counterpart of the 4-way demultiplexer in the Mux/DMux chip family.
- Four valid/ready producer ports feed one registered output port.
- Round-robin arbitration; out_sel tags each beat with its source way (00..11), so a downstream DMux4Way can route it back.
- Sits between per-way producers and a shared 16-bit datapath.

---
 rtl/mux4way_merge_pkg.sv | 18 +
 rtl/mux4way_merge_rr_arbiter4.sv | 30 +++
 rtl/mux4way_merge.sv | 84 ++++++++
 3 files changed

// File: rtl/mux4way_merge_pkg.sv
// Shared constants and helpers for the 4-way stream merger.
// Optional packet lock is enabled with MUX4WAY_LOCK_EN.
package mux4way_merge_pkg;

    localparam int NUM_WAYS  = 4;
    localparam int SEL_W     = 2;
    localparam int DEF_WIDTH = 16;

    typedef logic [SEL_W-1:0] way_t;

    function automatic logic [NUM_WAYS-1:0] way_onehot(input way_t w);
        logic [NUM_WAYS-1:0] oh;
        oh    = '0;
        oh[w] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux4way_merge_rr_arbiter4.sv
// Combinational round-robin arbiter: first requesting way at or after rr_ptr,
// wrapping mod 4. Produces one-hot grant (or zero) plus encoded index.
module rr_arbiter4
    import mux4way_merge_pkg::*;
(
    input  logic [NUM_WAYS-1:0] request,
    input  way_t                rr_ptr,
    output logic [NUM_WAYS-1:0] grant,
    output way_t                index
);

    logic found;
    way_t w;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        w     = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            w = rr_ptr + way_t'(k);
            if (!found && request[w]) begin
                found    = 1'b1;
                grant[w] = 1'b1;
                index    = w;
            end
        end
    end

endmodule

// File: rtl/mux4way_merge.sv
// 4-to-1 valid/ready stream merger with round-robin arbitration and one
// output register. Define MUX4WAY_LOCK_EN to hold the grant for a whole packet.
module mux4way_merge
    import mux4way_merge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_WAYS*WIDTH-1:0] in_data,
    input  logic [NUM_WAYS-1:0]       in_valid,
    input  logic [NUM_WAYS-1:0]       in_last,
    output logic [NUM_WAYS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [NUM_WAYS-1:0][WIDTH-1:0] way_data;
    logic [NUM_WAYS-1:0]            request;
    logic [NUM_WAYS-1:0]            grant;
    way_t                           rr_ptr;
    way_t                           arb_ptr;
    way_t                           index;
    logic                           load_en;
    logic                           accept;

    assign way_data = in_data;
    assign load_en  = ~out_valid | out_ready;
    assign in_ready = grant & {NUM_WAYS{load_en}};
    assign accept   = |in_ready;

`ifdef MUX4WAY_LOCK_EN
    logic lock;

    // While locked, out_sel still names the way that opened the packet,
    // since only that way can have been accepted since.
    assign request = lock ? (in_valid & way_onehot(out_sel)) : in_valid;
    assign arb_ptr = lock ? out_sel : rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock <= 1'b0;
        else if (accept)
            lock <= ~in_last[index];
    end
`else
    assign request = in_valid;
    assign arb_ptr = rr_ptr;
`endif

    rr_arbiter4 u_arb (
        .request (request),
        .rr_ptr  (arb_ptr),
        .grant   (grant),
        .index   (index)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= way_data[index];
            out_sel   <= index;
            out_last  <= in_last[index];
`ifdef MUX4WAY_LOCK_EN
            if (in_last[index])
                rr_ptr <= index + 2'd1;
`else
            rr_ptr    <= index + 2'd1;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
